// File: rtl/hazard_pkg.sv
// Shared types and constants for the D-stage hazard unit: forward selects, Tuse/Tnew encodings,
// shadow-pipe slot layout and MDU latencies. Pure declarations, no timing or flow control.
package hazard_pkg;

    typedef enum logic [1:0] {
        ODATA = 2'b00,
        EDATA = 2'b01,
        MDATA = 2'b10,
        WDATA = 2'b11
    } fwd_sel_e;

    localparam logic [1:0] TUSE_NONE   = 2'd3;
    localparam int         MD_CNT_W    = 4;
    localparam logic [MD_CNT_W-1:0] MD_MULT_CYC = 4'd5;
    localparam logic [MD_CNT_W-1:0] MD_DIV_CYC  = 4'd10;

    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
        logic       md;
    } slot_t;

    typedef struct packed {
        logic     stall;
        fwd_sel_e sel;
    } op_res_t;

    function automatic logic [1:0] tnew_age(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/d_hazard_ctrl_if.sv
// Decode-stage hazard interface: D-stage operand/destination info in, stall/forward selects out.
// Master is the decoder side, slave is the hazard controller.
interface d_hazard_ctrl_if;
    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic [1:0] D_Tuse_rs;
    logic [1:0] D_Tuse_rt;
    logic [4:0] D_wa;
    logic [1:0] D_Tnew;
    logic       D_md_start;
    logic       D_md_div;
    logic       D_md_use;
    logic       stall;
    logic [1:0] s_D_rs_data;
    logic [1:0] s_D_rt_data;
    logic       md_busy;

    modport master (
        output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_wa, D_Tnew,
        output D_md_start, D_md_div, D_md_use,
        input  stall, s_D_rs_data, s_D_rt_data, md_busy
    );

    modport slave (
        input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_wa, D_Tnew,
        input  D_md_start, D_md_div, D_md_use,
        output stall, s_D_rs_data, s_D_rt_data, md_busy
    );
endinterface

// File: rtl/md_busy_counter.sv
// MDU occupancy counter: loads the operation length, then counts down to 0; busy while non-zero.
// Load takes effect on the next edge; async reset aborts a running count immediately.
module md_busy_counter
    import hazard_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [MD_CNT_W-1:0] i_load_val,
    output logic [MD_CNT_W-1:0] o_value,
    output logic                o_busy
);

    logic [MD_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_value = r_cnt;
    assign o_busy  = (r_cnt != '0);

endmodule

// File: rtl/d_hazard_ctrl.sv
// D-stage hazard controller: shadow E/M/W pipe, zero-latency stall and forward selects; stall freezes PC/D.
// D_HAZARD_FWD_E_EN enables forwarding from E; without it every E match stalls.
module d_hazard_ctrl
    import hazard_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    d_hazard_ctrl_if.slave hz
);

    slot_t               r_e;
    slot_t               r_m;
    slot_t               r_w;
    logic                r_e_div;
    op_res_t             w_rs_res;
    op_res_t             w_rt_res;
    logic                w_md_stall;
    logic                w_stall;
    logic                w_md_busy;
    logic [MD_CNT_W-1:0] w_md_cnt;
    logic                w_unused_ok;

    // Youngest matching slot wins; W always forwards since its result is already available.
    function automatic op_res_t resolve_op(input logic [4:0] src, input logic [1:0] tuse,
                                           input slot_t e, input slot_t m, input slot_t w);
        op_res_t res;
        res.stall = 1'b0;
        res.sel   = ODATA;
        if (src != 5'd0 && tuse != TUSE_NONE) begin
            if (e.wa == src) begin
`ifdef D_HAZARD_FWD_E_EN
                if (e.tnew > tuse)
                    res.stall = 1'b1;
                else if (e.tnew == 2'd0)
                    res.sel = EDATA;
`else
                res.stall = 1'b1;
`endif
            end else if (m.wa == src) begin
                if (m.tnew > tuse)
                    res.stall = 1'b1;
                else if (m.tnew == 2'd0)
                    res.sel = MDATA;
            end else if (w.wa == src) begin
                res.sel = WDATA;
            end
        end
        return res;
    endfunction

    always_comb begin
        w_rs_res   = resolve_op(hz.D_rs, hz.D_Tuse_rs, r_e, r_m, r_w);
        w_rt_res   = resolve_op(hz.D_rt, hz.D_Tuse_rt, r_e, r_m, r_w);
        w_md_stall = hz.D_md_use && (w_md_busy || r_e.md);
        w_stall    = w_rs_res.stall || w_rt_res.stall || w_md_stall;
    end

    assign hz.stall       = w_stall;
    assign hz.s_D_rs_data = w_stall ? ODATA : w_rs_res.sel;
    assign hz.s_D_rt_data = w_stall ? ODATA : w_rt_res.sel;
    assign hz.md_busy     = w_md_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e     <= '0;
            r_m     <= '0;
            r_w     <= '0;
            r_e_div <= 1'b0;
        end else begin
            r_w <= r_m;
            r_m <= '{wa: r_e.wa, tnew: tnew_age(r_e.tnew), md: r_e.md};
            if (!w_stall) begin
                r_e     <= '{wa: hz.D_wa, tnew: hz.D_Tnew, md: hz.D_md_start};
                r_e_div <= hz.D_md_start && hz.D_md_div;
            end else begin
                r_e     <= '0;
                r_e_div <= 1'b0;
            end
        end
    end

    // The count starts on the edge where the mult/div leaves E, so busy picks up exactly as E.md drops.
    md_busy_counter u_md_busy_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (r_e.md),
        .i_load_val (r_e_div ? MD_DIV_CYC : MD_MULT_CYC),
        .o_value    (w_md_cnt),
        .o_busy     (w_md_busy)
    );

    assign w_unused_ok = ^{r_m.md, r_w.tnew, r_w.md, w_md_cnt};

endmodule

// File: tb/tb_d_hazard_ctrl.sv
// Directed bench for d_hazard_ctrl: hand-computed stall/select/busy expectations per scenario.
module tb_d_hazard_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   n_stall;
    int   n_busy;

    d_hazard_ctrl_if hz();

    d_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [1:0] tu_rs,
                         input logic [4:0] rt, input logic [1:0] tu_rt,
                         input logic [4:0] wa, input logic [1:0] tnew,
                         input logic st, input logic dv, input logic us);
        hz.D_rs       = rs;
        hz.D_Tuse_rs  = tu_rs;
        hz.D_rt       = rt;
        hz.D_Tuse_rt  = tu_rt;
        hz.D_wa       = wa;
        hz.D_Tnew     = tnew;
        hz.D_md_start = st;
        hz.D_md_div   = dv;
        hz.D_md_use   = us;
        #1;
    endtask

    task automatic set_idle();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic flush();
        set_idle();
        repeat (3) tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        set_idle();
        chk("rst_stall", hz.stall, 0);
        chk("rst_rs_sel", hz.s_D_rs_data, 0);
        chk("rst_rt_sel", hz.s_D_rt_data, 0);
        chk("rst_busy", hz.md_busy, 0);
        #10 reset = 1'b0;

        // register 0 never hazards
        set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("r0_stall", hz.stall, 0);
        chk("r0_rs_sel", hz.s_D_rs_data, 0);
        chk("r0_rt_sel", hz.s_D_rt_data, 0);

        // E{8,1} vs Tuse 0 stalls, then M{8,0} forwards, then W forwards
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("e8_stall", hz.stall, 1);
        chk("e8_rs_sel", hz.s_D_rs_data, 0);
        tick();
        chk("m8_stall", hz.stall, 0);
        chk("m8_rs_sel", hz.s_D_rs_data, 2);
        set_idle();
        tick();
        set_d(5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("w8_stall", hz.stall, 0);
        chk("w8_rs_sel", hz.s_D_rs_data, 3);
        flush();

        // E{9,0} vs rt Tuse 1
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 2'd3, 5'd9, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
`ifdef D_HAZARD_FWD_E_EN
        chk("e9_stall", hz.stall, 0);
        chk("e9_rt_sel", hz.s_D_rt_data, 1);
`else
        chk("e9_stall", hz.stall, 1);
        chk("e9_rt_sel", hz.s_D_rt_data, 0);
`endif
        flush();

        // M{10,1}: no stall for Tuse 1 (late correction), stall for Tuse 0
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd10, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        set_idle();
        tick();
        set_d(5'd10, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("m10_tu1_stall", hz.stall, 0);
        chk("m10_tu1_sel", hz.s_D_rs_data, 0);
        set_d(5'd10, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("m10_tu0_stall", hz.stall, 1);
        flush();

        // rt stall forces the otherwise-valid rs forward select to 00
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd13, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd12, 2'd0, 5'd13, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("force_stall", hz.stall, 1);
        chk("force_rs_sel", hz.s_D_rs_data, 0);
        chk("force_rt_sel", hz.s_D_rt_data, 0);
        set_d(5'd12, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("m12_rs_sel", hz.s_D_rs_data, 2);
        flush();

        // wa=5 in E, M and W: E has priority; then W alone
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        set_d(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
`ifdef D_HAZARD_FWD_E_EN
        chk("emw5_stall", hz.stall, 0);
        chk("emw5_rs_sel", hz.s_D_rs_data, 1);
`else
        chk("emw5_stall", hz.stall, 1);
        chk("emw5_rs_sel", hz.s_D_rs_data, 0);
`endif
        set_idle();
        repeat (2) tick();
        set_d(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("w5_rs_sel", hz.s_D_rs_data, 3);
        flush();

        // div then mfhi: 11 stall cycles, 10 busy cycles
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        chk("div_issue_stall", hz.stall, 0);
        tick();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("div_e_busy", hz.md_busy, 0);
        n_stall = 0;
        n_busy  = 0;
        for (int i = 0; i < 30 && hz.stall; i++) begin
            n_stall++;
            if (hz.md_busy) n_busy++;
            tick();
        end
        chk("div_stall_cycles", n_stall, 11);
        chk("div_busy_cycles", n_busy, 10);
        chk("div_release_busy", hz.md_busy, 0);
        flush();

        // mult aborted by async reset, then a fresh mult counts 5 again
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
        tick();
        set_idle();
        repeat (3) tick();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("mult_mid_busy", hz.md_busy, 1);
        chk("mult_mid_stall", hz.stall, 1);
        #1 reset = 1'b1;
        #1;
        chk("abort_busy", hz.md_busy, 0);
        chk("abort_stall", hz.stall, 0);
        #2 reset = 1'b0;
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
        tick();
        set_idle();
        tick();
        n_busy = 0;
        for (int i = 0; i < 20 && hz.md_busy; i++) begin
            n_busy++;
            tick();
        end
        chk("mult_restart_cycles", n_busy, 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
